// File: rtl/mult_share_arbiter_pkg.sv
// mult_arb_pkg
//   Shared types and helpers for the multiplier-sharing arbiter.
//   - state_t   : controller state (IDLE, CALC, RESP)
//   - DEF_W     : default operand width
//   - DEF_NREQ  : default number of requesters
//   - next_idx  : increment an index with wrap-around modulo n
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_W    = 32;
  localparam int DEF_NREQ = 2;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request found when
//   scanning upward from ptr, wrapping modulo N.
//   Ports:
//     req  in  N   request vector
//     ptr  in  PW  index holding highest priority (must be < N)
//     gnt  out N   one-hot grant, all zero when no request is asserted
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one external multiplier among NREQ requesters. One request is
//   granted at a time (round robin), its operands are registered onto
//   mul_a/mul_b, the product is sampled MUL_LAT cycles later and returned
//   on the granted requester's result channel.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     req_valid/req_ready per-requester operand handshake (NREQ bits)
//     req_a/req_b         packed operands, requester i owns [i*W +: W]
//     rsp_valid/rsp_ready per-requester result handshake (NREQ bits)
//     rsp_data            product (2*W), shared, qualified by rsp_valid
//     busy                high whenever not idle
//     mul_a/mul_b         registered operands to the multiplier
//     mul_p               product from the multiplier
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int MUL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_data,
  output logic              busy,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  state_t            state_reg, state_next;
  logic [PW-1:0]     gid_reg, gid_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [W-1:0]      mul_a_reg, mul_a_next;
  logic [W-1:0]      mul_b_reg, mul_b_next;
  logic [2*W-1:0]    rsp_data_reg, rsp_data_next;
  logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;

  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gnt_idx;
  logic [W-1:0]      sel_a, sel_b;
  logic [W-1:0]      a_masked [NREQ];
  logic [W-1:0]      b_masked [NREQ];

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (gnt)
  );

  // Only the granted slice reaches the operand mux; other requesters'
  // operands are masked to zero.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign a_masked[gi] = gnt[gi] ? req_a[gi*W +: W] : '0;
    assign b_masked[gi] = gnt[gi] ? req_b[gi*W +: W] : '0;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_a = sel_a | a_masked[k];
      sel_b = sel_b | b_masked[k];
      if (gnt[k]) gnt_idx = PW'(k);
    end
  end

  assign req_ready = (state_reg == IDLE) ? gnt : '0;

  always_comb begin
    state_next     = state_reg;
    gid_next       = gid_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    mul_a_next     = mul_a_reg;
    mul_b_next     = mul_b_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_valid_next = rsp_valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (|(req_valid & req_ready)) begin
          mul_a_next = sel_a;
          mul_b_next = sel_b;
          gid_next   = gnt_idx;
          cnt_next   = CW'(MUL_LAT);
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == '0) begin
          rsp_data_next  = mul_p;
          rsp_valid_next = NREQ'(1) << gid_reg;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[gid_reg]) begin
          rsp_valid_next = '0;
          // The requester just served drops to lowest priority.
          rr_ptr_next    = PW'(next_idx(int'(gid_reg), NREQ));
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gid_reg       <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gid_reg       <= gid_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
      mul_a_reg     <= mul_a_next;
      mul_b_reg     <= mul_b_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign busy      = (state_reg != IDLE);

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(rsp_valid));
  a_rsp_data_stable: assert property (@(posedge clk) disable iff (rst)
    (|rsp_valid && !rsp_ready[gid_reg]) |=> $stable(rsp_data));

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Two instances: inst 0 (NREQ=2, combinational multiplier) and
//   inst 1 (NREQ=4, 3-cycle pipelined multiplier). Each transaction's
//   grant, product and timing are predicted from a round-robin pointer
//   kept per instance; directed scenarios are followed by random rounds.
module tb_mult_share_arbiter;

  logic clk;
  logic rst;

  logic [3:0]   rv  [2];
  logic [3:0]   rsr [2];
  logic [127:0] ra  [2];
  logic [127:0] rb  [2];
  logic [3:0]   rqr [2];
  logic [3:0]   rsv [2];
  logic [63:0]  rd  [2];
  logic [31:0]  ma  [2];
  logic [31:0]  mb  [2];
  logic         bsy [2];

  logic [1:0]  rqr0, rsv0;
  logic [3:0]  rqr1, rsv1;
  logic [63:0] rd0, rd1, mp0, mp1;
  logic [31:0] ma0, mb0, ma1, mb1;
  logic        bsy0, bsy1;
  logic [63:0] p1, p2, p3;

  int checks   = 0;
  int failures = 0;
  int ptr_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(2), .W(32), .MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0][1:0]), .req_ready(rqr0),
    .req_a(ra[0][63:0]), .req_b(rb[0][63:0]),
    .rsp_valid(rsv0), .rsp_ready(rsr[0][1:0]),
    .rsp_data(rd0), .busy(bsy0),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0)
  );

  mult_share_arbiter #(.NREQ(4), .W(32), .MUL_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rqr1),
    .req_a(ra[1]), .req_b(rb[1]),
    .rsp_valid(rsv1), .rsp_ready(rsr[1]),
    .rsp_data(rd1), .busy(bsy1),
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1)
  );

  // External multipliers: combinational for inst 0, 3-stage pipe for inst 1.
  assign mp0 = 64'(ma0) * 64'(mb0);
  always @(posedge clk) begin
    p1 <= 64'(ma1) * 64'(mb1);
    p2 <= p1;
    p3 <= p2;
  end
  assign mp1 = p3;

  assign rqr[0] = {2'b00, rqr0};
  assign rsv[0] = {2'b00, rsv0};
  assign rqr[1] = rqr1;
  assign rsv[1] = rsv1;
  assign rd[0]  = rd0;
  assign rd[1]  = rd1;
  assign ma[0]  = ma0;
  assign ma[1]  = ma1;
  assign mb[0]  = mb0;
  assign mb[1]  = mb1;
  assign bsy[0] = bsy0;
  assign bsy[1] = bsy1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [127:0] rand_ops();
    return {rand_op(), rand_op(), rand_op(), rand_op()};
  endfunction

  task automatic check_reset(input int inst);
    check($sformatf("rst_req_ready%0d", inst), 64'(rqr[inst]), 64'(0));
    check($sformatf("rst_rsp_valid%0d", inst), 64'(rsv[inst]), 64'(0));
    check($sformatf("rst_rsp_data%0d", inst),  rd[inst],       64'(0));
    check($sformatf("rst_mul_a%0d", inst),     64'(ma[inst]),  64'(0));
    check($sformatf("rst_mul_b%0d", inst),     64'(mb[inst]),  64'(0));
    check($sformatf("rst_busy%0d", inst),      64'(bsy[inst]), 64'(0));
  endtask

  // Called just after a negedge with the DUT idle; returns just after a
  // negedge with the DUT idle again (the response handshake cycle + 1).
  task automatic do_txn(input int inst, input logic [3:0] mask,
                        input logic [127:0] a, input logic [127:0] b,
                        input int bp, input bit hold, output int g);
    int n, lat;
    logic [3:0]  oh;
    logic [63:0] prod;
    n   = (inst == 0) ? 2 : 4;
    lat = (inst == 0) ? 0 : 3;
    g   = -1;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (ptr_m[inst] + k) % n;
      if (g < 0 && mask[idx]) g = idx;
    end
    oh   = 4'b0001 << g;
    prod = 64'(a[g*32 +: 32]) * 64'(b[g*32 +: 32]);

    rv[inst] = mask; ra[inst] = a; rb[inst] = b; rsr[inst] = 4'b0;
    #1;
    check("grant", 64'(rqr[inst]), 64'(oh));
    check("busy_idle", 64'(bsy[inst]), 64'(0));

    @(negedge clk);
    rv[inst] = hold ? (mask & ~oh) : 4'b0;
    ra[inst][g*32 +: 32] = $urandom;
    rb[inst][g*32 +: 32] = $urandom;
    #1;
    check("mul_a", 64'(ma[inst]), 64'(a[g*32 +: 32]));
    check("mul_b", 64'(mb[inst]), 64'(b[g*32 +: 32]));
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      check("calc_rsp_valid", 64'(rsv[inst]), 64'(0));
      check("calc_req_ready", 64'(rqr[inst]), 64'(0));
      check("calc_busy", 64'(bsy[inst]), 64'(1));
    end

    @(negedge clk); #1;
    check("rsp_valid", 64'(rsv[inst]), 64'(oh));
    check("rsp_data", rd[inst], prod);
    for (int i = 0; i < bp; i++) begin
      rsr[inst] = 4'($urandom) & ~oh;
      @(negedge clk); #1;
      check("bp_rsp_valid", 64'(rsv[inst]), 64'(oh));
      check("bp_rsp_data", rd[inst], prod);
      check("bp_req_ready", 64'(rqr[inst]), 64'(0));
      check("bp_busy", 64'(bsy[inst]), 64'(1));
    end
    rsr[inst] = oh | 4'($urandom);
    @(negedge clk);
    rsr[inst] = 4'b0;
    rv[inst]  = 4'b0;
    #1;
    check("done_rsp_valid", 64'(rsv[inst]), 64'(0));
    check("done_busy", 64'(bsy[inst]), 64'(0));
    ptr_m[inst] = (g + 1) % n;
    $display("txn inst=%0d mask=%b grant=%0d a=%0h b=%0h p=%0h bp=%0d",
             inst, mask, g, a[g*32 +: 32], b[g*32 +: 32], prod, bp);
  endtask

  initial begin
    int g;
    logic [3:0] m;
    for (int i = 0; i < 2; i++) begin
      rv[i] = '0; rsr[i] = '0; ra[i] = '0; rb[i] = '0; ptr_m[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    // Single request on inst 0: 7*6.
    do_txn(0, 4'b0001, 128'({32'd0, 32'd7}), 128'({32'd0, 32'd6}), 0, 1'b0, g);
    check("single_order", 64'(g), 64'(0));

    // Backpressure: requester 1 wins (ptr=1), requester 0 keeps waiting.
    do_txn(0, 4'b0011, 128'({32'hFFFF_FFFF, 32'd9}), 128'({32'hFFFF_FFFF, 32'd9}), 5, 1'b1, g);
    check("bp_order", 64'(g), 64'(1));

    // Pipelined multiplier: 1234*5678 on inst 1.
    do_txn(1, 4'b0001, 128'(1234), 128'(5678), 0, 1'b0, g);
    check("pipe_order", 64'(g), 64'(0));

    // Wrap-around on inst 1: move ptr to 3, then only 3 and 0 valid.
    do_txn(1, 4'b0100, rand_ops(), rand_ops(), 0, 1'b0, g);
    check("wrap_pre", 64'(g), 64'(2));
    do_txn(1, 4'b1001, rand_ops(), rand_ops(), 1, 1'b1, g);
    check("wrap_a", 64'(g), 64'(3));
    do_txn(1, 4'b1001, rand_ops(), rand_ops(), 0, 1'b1, g);
    check("wrap_b", 64'(g), 64'(0));
    do_txn(1, 4'b1001, rand_ops(), rand_ops(), 2, 1'b1, g);
    check("wrap_c", 64'(g), 64'(3));

    // Reset while inst 1 is calculating, after moving its pointer to 2.
    do_txn(1, 4'b0010, rand_ops(), rand_ops(), 0, 1'b0, g);
    check("pre_abort", 64'(g), 64'(1));
    rv[1] = 4'b1000; ra[1] = rand_ops(); rb[1] = rand_ops();
    #1;
    check("abort_grant", 64'(rqr[1]), 64'(4'b1000));
    @(negedge clk);
    rv[1] = 4'b0;
    rst   = 1'b1;
    #1;
    check("abort_busy", 64'(bsy[1]), 64'(1));
    @(negedge clk); #1;
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
    repeat (6) begin
      @(negedge clk); #1;
      check("abort_no_rsp", 64'(rsv[1]), 64'(0));
    end
    do_txn(1, 4'b1111, rand_ops(), rand_ops(), 0, 1'b0, g);
    check("post_abort", 64'(g), 64'(0));

    // Contention on inst 0 from reset: (3,5) and (10,10), then 0,1,0,1.
    do_txn(0, 4'b0011, 128'({32'd10, 32'd3}), 128'({32'd10, 32'd5}), 0, 1'b1, g);
    check("cont_first", 64'(g), 64'(0));
    do_txn(0, 4'b0011, 128'({32'd10, 32'd3}), 128'({32'd10, 32'd5}), 0, 1'b1, g);
    check("cont_second", 64'(g), 64'(1));
    for (int t = 0; t < 4; t++) begin
      do_txn(0, 4'b0011, rand_ops(), rand_ops(), 0, 1'b1, g);
      check("cont_rr", 64'(g), 64'(t % 2));
    end

    // Random rounds on both instances.
    for (int inst = 0; inst < 2; inst++) begin
      for (int r = 0; r < 30; r++) begin
        m = (inst == 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(1, 15));
        do_txn(inst, m, rand_ops(), rand_ops(), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), g);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one multiplier datapath (the dadda multiplier instance, external to this block) among NREQ requesters.
- Each requester has a valid/ready operand channel and a valid/ready result channel.
- The block round-robin grants one request at a time, drives the multiplier operands, and waits a fixed latency. It then registers the product and returns it to the granted requester.
- It sits between the test/stimulus interfaces and the multiplier, replacing the single-client control FSM.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand width in bits; the product is 2*W.
- MUL_LAT, 0, pipeline depth of the attached multiplier in cycles (0 = combinational).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester operand accept.
- req_a  in  NREQ*W  packed operand A; requester i owns slice [i*W +: W].
- req_b  in  NREQ*W  packed operand B; same slicing.
- rsp_valid  out  NREQ  per-requester result valid; at most one bit set.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_data  out  2*W  product, shared by all result channels, qualified by rsp_valid.
- busy  out  1  high whenever state != IDLE.
- mul_a  out  W  operand A to the multiplier (registered).
- mul_b  out  W  operand B to the multiplier (registered).
- mul_p  in  2*W  product from the multiplier.

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; mul_a=0; mul_b=0; busy=0; rr_ptr=0; wait counter=0.
- Reset asserted mid-operation aborts the transaction and drops the result; no response is produced for it.
- FSM states:
  - IDLE: grant = first asserted req_valid scanning upward from rr_ptr, wrapping modulo NREQ.
    - req_ready[i] = (state==IDLE) && grant[i]; combinational and one-hot, or zero if no req_valid.
    - On req_valid[g] && req_ready[g]: register mul_a/mul_b from slice g, latch gid=g, cnt=MUL_LAT, go to CALC.
  - CALC: if cnt==0, sample rsp_data<=mul_p, set rsp_valid[gid]<=1, go to RESP; else cnt<=cnt-1.
  - RESP: hold rsp_data and rsp_valid[gid] stable.
    - On rsp_ready[gid]: rsp_valid<=0, rr_ptr<=(gid+1) mod NREQ, go to IDLE.
    - rsp_ready on other indices is ignored.
- Latency: request handshake at cycle t -> rsp_valid high at t+2+MUL_LAT. The next grant is possible in the cycle after the response handshake.
- Throughput: one transaction per 3+MUL_LAT cycles with an immediate rsp_ready.
- Arithmetic: unsigned. rsp_data is exactly the multiplier's 2*W output; no truncation or sign handling here.
- mul_a/mul_b hold their value until the next grant so a pipelined multiplier sees stable operands.
- Fairness: after serving g, g has lowest priority. With all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
- req_valid dropped before grant: no effect. req_ready is never asserted outside IDLE.
- Operands of non-granted requesters are not sampled.
- Simultaneous request from the just-served requester and another: the other wins.
- Assertions: $onehot0(req_ready); $onehot0(rsp_valid); rsp_data stable while rsp_valid && !rsp_ready.

Decomposition:
- Package mult_arb_pkg:
  - state enum {IDLE, CALC, RESP} as logic [1:0].
  - default W and NREQ localparams.
  - helper function next_idx(idx, n) for modulo wrap.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; output one-hot gnt[N]; purely combinational.
- The top holds the FSM, counter, operand/result registers, and the pointer update.

Test Plan:
- Single request, MUL_LAT=0: requester 0 sends A=7, B=6. Expect req_ready[0] in the same cycle, rsp_valid[0] 2 cycles later with rsp_data=42, and busy high throughout.
- Contention, NREQ=2: both valid with (3,5) and (10,10) from reset. Grant order is 0 then 1; responses are 15 then 100; rr_ptr ends at 0. With both held valid for 4 transactions, the order is 0,1,0,1.
- Backpressure: requester 1 sends (0xFFFFFFFF, 0xFFFFFFFF) with rsp_ready low for 5 cycles. Expect rsp_data=0xFFFFFFFE00000001 held stable, and req_ready all zero while requester 0 waits.
- Pipelined multiplier, MUL_LAT=3 (bench model with 3-cycle delay): A=1234, B=5678. Expect rsp_valid exactly 5 cycles after the handshake, with rsp_data=7006652.
- Reset mid-operation: assert rst while in CALC. Next cycle all outputs are at reset values, and no rsp_valid follows. A new request afterwards is granted starting from index 0.
- Wrap-around, NREQ=4: only requesters 3 and 0 valid, rr_ptr=3. Grant order is 3,0,3; no grant to idle indices.
